// File: rtl/bus_sequencer.sv
// bus_sequencer: multiplexes a 16-bit address and data onto an 8-bit bus in ADL/ADH/DATA/DONE phases and owns the PC
module bus_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic [2:0]  pc_enable,
  input  logic [1:0]  address_select,
  input  logic [15:0] memory_address,
  input  logic [7:0]  alu_result,
  input  logic        rw,
  input  logic [7:0]  data_out,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic [1:0]  bus_phase,
  output logic        bus_rw,
  output logic [7:0]  data_in,
  output logic        clk_enable,
  output logic [15:0] pc
);
  localparam logic [1:0] P_ADL = 2'd0, P_ADH = 2'd1, P_DATA = 2'd2, P_DONE = 2'd3;
  logic [1:0] state, next_state;
  logic [15:0] eff_addr;
  logic [7:0] addr_hi;
  logic [3:0] wait_q;
  assign eff_addr = address_select == 2'd1 ? memory_address :
                    address_select == 2'd2 ? {8'h00, alu_result} : pc;
  assign bus_phase = state;
  always_ff @(posedge clk)
    state <= !rst_n ? P_ADL : next_state;
  always_comb
    next_state = state == P_ADL  ? (halt ? P_ADL : P_ADH) :
                 state == P_ADH  ? P_DATA :
                 state == P_DATA ? (wait_q == 4'd0 ? P_DONE : P_DATA) : P_ADL;
  always_ff @(posedge clk)
    if (!rst_n) begin
      pc         <= RESET_PC;
      bus_out    <= 8'h00;
      bus_oe     <= 1'b0;
      bus_rw     <= 1'b1;
      data_in    <= 8'h00;
      clk_enable <= 1'b0;
      wait_q     <= 4'd0;
      addr_hi    <= 8'h00;
    end else begin
      clk_enable <= state == P_DATA && wait_q == 4'd0;
      bus_oe     <= state == P_DATA && !bus_rw;
      if (state == P_ADL && !halt) begin
        addr_hi <= eff_addr[15:8];
        bus_rw  <= rw;
        bus_out <= eff_addr[7:0];
      end
      if (state == P_ADH) begin
        bus_out <= addr_hi;
        wait_q  <= 4'(WAIT_STATES);
      end
      if (state == P_DATA) begin
        if (!bus_rw) bus_out <= data_out;
        if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
        else if (bus_rw) data_in <= bus_in;
      end
      if (state == P_DONE)
        pc <= pc_enable == 3'b011 ? pc + 16'd1 :
              pc_enable == 3'b001 ? memory_address : pc;
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: scoreboard bench for bus_sequencer with zero and two wait states
module tb_bus_sequencer;
  typedef struct packed {
    logic [7:0]  adl, adh, bo, di;
    logic        rw;
    logic [15:0] pc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, halt = 1'b0, halt2 = 1'b1, rw = 1'b1;
  logic [2:0] pc_enable = 3'b011;
  logic [1:0] address_select = 2'd0;
  logic [15:0] memory_address = 16'h0000;
  logic [7:0] alu_result = 8'h00, data_out = 8'h00, bus_in = 8'hA5;
  logic [7:0] bo [2], di [2];
  logic [1:0] ph [2];
  logic oe [2], brw [2], ce [2];
  logic [15:0] pcv [2];
  exp_t q0[$], q1[$];
  exp_t e_m;
  int tests = 0, fails = 0;
  int wst [2] = '{0, 2};
  logic [7:0] c_adl [2], c_adh [2];
  logic [1:0] pph [2];
  int cyc [2], oec [2];
  logic pc_chk [2];
  logic [15:0] pc_exp [2];

  bus_sequencer #(.RESET_PC(16'h8000), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .halt(halt), .pc_enable(pc_enable),
    .address_select(address_select), .memory_address(memory_address),
    .alu_result(alu_result), .rw(rw), .data_out(data_out), .bus_in(bus_in),
    .bus_out(bo[0]), .bus_oe(oe[0]), .bus_phase(ph[0]), .bus_rw(brw[0]),
    .data_in(di[0]), .clk_enable(ce[0]), .pc(pcv[0]));

  bus_sequencer #(.RESET_PC(16'h8000), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .halt(halt2), .pc_enable(pc_enable),
    .address_select(address_select), .memory_address(memory_address),
    .alu_result(alu_result), .rw(rw), .data_out(data_out), .bus_in(bus_in),
    .bus_out(bo[1]), .bus_oe(oe[1]), .bus_phase(ph[1]), .bus_rw(brw[1]),
    .data_in(di[1]), .clk_enable(ce[1]), .pc(pcv[1]));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [7:0] adl, adh, bo_e, di_e, logic r, logic [15:0] p);
    return '{adl: adl, adh: adh, bo: bo_e, di: di_e, rw: r, pc: p};
  endfunction

  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (!rst_n) begin
        cyc[d] = 0;
        oec[d] = 0;
        pph[d] = 2'd0;
        pc_chk[d] = 1'b0;
      end else begin
        if (pc_chk[d]) begin
          check($sformatf("pc_after_cycle dut%0d", d), pcv[d], pc_exp[d]);
          pc_chk[d] = 1'b0;
        end
        if (ph[d] == 2'd1 && pph[d] != 2'd1) begin
          c_adl[d] = bo[d];
          cyc[d] = 0;
          oec[d] = 0;
        end
        if (ph[d] == 2'd2 && pph[d] == 2'd1) c_adh[d] = bo[d];
        if (ph[d] != 2'd0) cyc[d]++;
        oec[d] += int'(oe[d]);
        if (ce[d]) begin
          check($sformatf("phase_at_clk_enable dut%0d", d), ph[d], 2'd3);
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_clk_enable dut%0d: got clk_enable=1 expected 0", d);
          end else begin
            if (d == 0) e_m = q0.pop_front();
            else e_m = q1.pop_front();
            check($sformatf("adl dut%0d", d), c_adl[d], e_m.adl);
            check($sformatf("adh dut%0d", d), c_adh[d], e_m.adh);
            check($sformatf("bus_out_done dut%0d", d), bo[d], e_m.bo);
            check($sformatf("data_in dut%0d", d), di[d], e_m.di);
            check($sformatf("bus_rw dut%0d", d), brw[d], e_m.rw);
            check($sformatf("oe_clks dut%0d", d), oec[d], e_m.rw ? 0 : wst[d] + 1);
            check($sformatf("cycle_len dut%0d", d), cyc[d] + 1, 4 + wst[d]);
            pc_exp[d] = e_m.pc;
            pc_chk[d] = 1'b1;
          end
        end
        pph[d] = ph[d];
      end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(int d, int limit);
    int n = 0;
    while (!ce[d] && n < limit) begin
      step(1);
      n++;
    end
    check($sformatf("timeout dut%0d", d), ce[d], 1'b1);
    step(1);
  endtask

  task automatic drive(logic [1:0] s, logic [15:0] ma, logic [7:0] alu, logic r,
                       logic [7:0] dout, logic [7:0] bin, logic [2:0] pce);
    address_select = s;
    memory_address = ma;
    alu_result = alu;
    rw = r;
    data_out = dout;
    bus_in = bin;
    pc_enable = pce;
  endtask

  task automatic cycle0(logic [1:0] s, logic [15:0] ma, logic [7:0] alu, logic r,
                        logic [7:0] dout, logic [7:0] bin, logic [2:0] pce, exp_t e);
    drive(s, ma, alu, r, dout, bin, pce);
    q0.push_back(e);
    wait_done(0, 20);
  endtask

  initial begin
    step(2);
    check("rst_bus_out", bo[0], 8'h00);
    check("rst_bus_oe", oe[0], 1'b0);
    check("rst_phase", ph[0], 2'd0);
    check("rst_bus_rw", brw[0], 1'b1);
    check("rst_data_in", di[0], 8'h00);
    check("rst_clk_enable", ce[0], 1'b0);
    check("rst_pc", pcv[0], 16'h8000);
    rst_n = 1'b1;
    cycle0(2'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'hA5, 3'b011, mk(8'h00, 8'h80, 8'h80, 8'hA5, 1'b1, 16'h8001));
    cycle0(2'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h3C, 3'b000, mk(8'h01, 8'h80, 8'h80, 8'h3C, 1'b1, 16'h8001));
    cycle0(2'd1, 16'h1234, 8'h00, 1'b0, 8'h5A, 8'hEE, 3'b000, mk(8'h34, 8'h12, 8'h5A, 8'h3C, 1'b0, 16'h8001));
    cycle0(2'd2, 16'hFFFF, 8'h7F, 1'b1, 8'h00, 8'hC3, 3'b001, mk(8'h7F, 8'h00, 8'h00, 8'hC3, 1'b1, 16'hFFFF));
    cycle0(2'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h99, 3'b011, mk(8'hFF, 8'hFF, 8'hFF, 8'h99, 1'b1, 16'h0000));
    cycle0(2'd0, 16'hC000, 8'h00, 1'b1, 8'h00, 8'h11, 3'b001, mk(8'h00, 8'h00, 8'h00, 8'h11, 1'b1, 16'hC000));
    cycle0(2'd3, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h22, 3'b000, mk(8'h00, 8'hC0, 8'hC0, 8'h22, 1'b1, 16'hC000));
    halt = 1'b1;
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h33, 3'b011);
    step(5);
    check("halt_phase", ph[0], 2'd0);
    check("halt_pc", pcv[0], 16'hC000);
    halt = 1'b0;
    cycle0(2'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h44, 3'b011, mk(8'h00, 8'hC0, 8'hC0, 8'h44, 1'b1, 16'hC001));
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h55, 3'b011);
    q0.push_back(mk(8'h01, 8'hC0, 8'hC0, 8'h55, 1'b1, 16'hC002));
    step(1);
    check("halt_mid_phase", ph[0], 2'd1);
    halt = 1'b1;
    wait_done(0, 20);
    step(4);
    check("halt_hold_phase", ph[0], 2'd0);
    check("halt_hold_pc", pcv[0], 16'hC002);
    halt = 1'b0;
    drive(2'd1, 16'h2000, 8'h00, 1'b0, 8'h77, 8'h00, 3'b001);
    step(2);
    check("pre_reset_phase", ph[0], 2'd2);
    rst_n = 1'b0;
    step(1);
    check("midrst_bus_oe", oe[0], 1'b0);
    check("midrst_phase", ph[0], 2'd0);
    check("midrst_clk_enable", ce[0], 1'b0);
    check("midrst_pc", pcv[0], 16'h8000);
    halt = 1'b1;
    rst_n = 1'b1;
    halt2 = 1'b0;
    drive(2'd0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h11, 3'b011);
    q1.push_back(mk(8'h00, 8'h80, 8'h80, 8'h22, 1'b1, 16'h8001));
    step(4);
    bus_in = 8'h22;
    wait_done(1, 10);
    halt2 = 1'b1;
    step(3);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
